// File: rtl/if_fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package if_fetch_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_BUS_WIDTH  = 32;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  // Sequential fetch stride in bytes (one 32-bit instruction word).
  localparam int PC_INCR = 4;

  // True when the slots already committed (in flight, buffered, or waiting to
  // be discarded) leave room for one more request in the 2-entry buffer.
  function automatic logic has_credit(input logic [1:0] in_flight,
                                      input logic [1:0] buffered,
                                      input logic [1:0] dropping);
    return ({1'b0, in_flight} + {1'b0, buffered} + {1'b0, dropping}) < 3'd2;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO with a flush that empties it in one cycle.
// Push and pop in the same cycle are both honoured.
module fetch_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop    = pop & (count != 2'd0);
  assign do_push   = push & ((count != 2'd2) | do_pop);
  assign head_data = mem[rd_ptr];

  // Storage array; contents past the head are don't-care so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; flush and reset both return to empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues sequential fetches to
// instruction memory, buffers up to two {pc, instruction} pairs and presents
// the oldest one to the IF/ID register. Redirects from EX discard everything
// in flight; responses already requested are counted and thrown away.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int                    BUS_WIDTH  = DEFAULT_BUS_WIDTH,
  parameter logic [BUS_WIDTH-1:0]  RESET_PC   = BUS_WIDTH'(DEFAULT_RESET_PC),
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(DEFAULT_NOP_INSTR)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [BUS_WIDTH-1:0]  imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  jump_en,
  input  logic [BUS_WIDTH-1:0]  jump_addr,
  input  logic                  hold,
  output logic [DATA_WIDTH-1:0] instruction_o,
  output logic [BUS_WIDTH-1:0]  pc_o,
  output logic                  valid_o
);

  localparam int ENTRY_WIDTH = BUS_WIDTH + DATA_WIDTH;

  logic [BUS_WIDTH-1:0]   pc_q;
  logic [1:0]             outstanding;
  logic [1:0]             drop_cnt;

  logic [1:0]             pcq_count;
  logic [BUS_WIDTH-1:0]   pcq_head;
  logic [1:0]             buf_count;
  logic [ENTRY_WIDTH-1:0] buf_head;

  logic                   head_valid;
  logic                   pop;
  logic [1:0]             eff_count;
  logic                   req_fire;
  logic                   rsp_fire;
  logic                   rsp_drop;
  logic                   rsp_keep;
  logic [BUS_WIDTH-1:0]   jump_target;

  // A slot freed by this cycle's pop can be re-requested immediately, which is
  // what sustains one instruction per cycle behind a single-cycle memory.
  assign head_valid  = buf_count != 2'd0;
  assign pop         = head_valid & ~hold & ~jump_en;
  assign eff_count   = buf_count - {1'b0, pop};
  assign jump_target = jump_addr & ~BUS_WIDTH'(3);

  assign imem_req_valid = has_credit(outstanding, eff_count, drop_cnt) & ~jump_en & ~rst;
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response belongs to a discarded request if drops are pending, or if a
  // redirect is happening in the very cycle it arrives.
  assign rsp_fire = imem_rsp_valid & (outstanding != 2'd0) & (pcq_count != 2'd0 | drop_cnt != 2'd0 | jump_en);
  assign rsp_drop = rsp_fire & (jump_en | (drop_cnt != 2'd0));
  assign rsp_keep = rsp_fire & ~rsp_drop;

  assign valid_o       = head_valid & ~jump_en;
  assign pc_o          = valid_o ? buf_head[ENTRY_WIDTH-1:DATA_WIDTH] : '0;
  assign instruction_o = valid_o ? buf_head[DATA_WIDTH-1:0] : NOP_INSTR;

  // PCs of accepted requests, matched in order with returning responses.
  fetch_fifo #(.WIDTH(BUS_WIDTH)) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (jump_en),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (rsp_keep),
    .head_data (pcq_head),
    .count     (pcq_count)
  );

  // Fetched {pc, instruction} pairs waiting for IF/ID.
  fetch_fifo #(.WIDTH(ENTRY_WIDTH)) u_fetch_buffer (
    .clk       (clk),
    .rst       (rst),
    .flush     (jump_en),
    .push      (rsp_keep),
    .push_data ({pcq_head, imem_rsp_data}),
    .pop       (pop),
    .head_data (buf_head),
    .count     (buf_count)
  );

  // PC, in-flight counter and pending-drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
    end else begin
      outstanding <= outstanding + {1'b0, req_fire} - {1'b0, rsp_fire};
      if (jump_en) begin
        pc_q     <= jump_target;
        drop_cnt <= outstanding - {1'b0, rsp_fire};
      end else begin
        if (req_fire) pc_q <= pc_q + BUS_WIDTH'(PC_INCR);
        if (rsp_drop) drop_cnt <= drop_cnt - 2'd1;
      end
    end
  end

  // Memory must never answer when nothing has been requested.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && outstanding == 2'd0))
        else $error("if_fetch: response with no request outstanding");
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed cycle table, hand-written corner
// sequences and a randomized run against a program-order reference model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        hold;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        valid_o;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .jump_en        (jump_en),
    .jump_addr      (jump_addr),
    .hold           (hold),
    .instruction_o  (instruction_o),
    .pc_o           (pc_o),
    .valid_o        (valid_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int pops   = 0;

  // Memory model: accepted requests waiting for their in-order response.
  typedef struct { logic [31:0] addr; int acc_cyc; } mem_req_t;
  mem_req_t mem_q[$];

  // Reference: program order the stage must deliver and must request in.
  logic [31:0] exp_pop_pc;
  logic [31:0] exp_req_addr;

  typedef struct {
    logic        rst;
    logic        hold;
    logic        ready;
    logic        jump;
    logic [31:0] jaddr;
    logic        rsp_en;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_req;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0003;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Program-order checks and memory bookkeeping for the current cycle.
  task automatic scoreCycle();
    if (rst) begin
      mem_q.delete();
      exp_pop_pc   = DEFAULT_RESET_PC;
      exp_req_addr = DEFAULT_RESET_PC;
      return;
    end
    if (jump_en) begin
      checkOutput("valid_in_jump", {31'd0, valid_o}, 32'd0);
      checkOutput("req_in_jump", {31'd0, imem_req_valid}, 32'd0);
    end
    if (!valid_o) begin
      checkOutput("idle_pc", pc_o, 32'd0);
      checkOutput("idle_instr", instruction_o, DEFAULT_NOP_INSTR);
    end else begin
      checkOutput("instr_matches_pc", instruction_o, mem_word(pc_o));
    end
    if (valid_o && !hold && !jump_en) begin
      checkOutput("pop_pc_order", pc_o, exp_pop_pc);
      exp_pop_pc = exp_pop_pc + 32'd4;
      pops++;
    end
    if (imem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      checkOutput("req_addr_order", imem_addr, exp_req_addr);
      exp_req_addr = exp_req_addr + 32'd4;
      mem_q.push_back('{imem_addr, cyc});
      checkOutput("in_flight_bound", {31'd0, mem_q.size() > 2}, 32'd0);
    end
    if (jump_en) begin
      exp_pop_pc   = {jump_addr[31:2], 2'b00};
      exp_req_addr = {jump_addr[31:2], 2'b00};
    end
  endtask

  // Drive one cycle's inputs (and memory response), settle, then score.
  task automatic applyStimulus(input logic r, input logic h, input logic rdy,
                               input logic j, input logic [31:0] ja, input logic rsp_en);
    rst            = r;
    hold           = h;
    imem_req_ready = rdy;
    jump_en        = j;
    jump_addr      = ja;
    if (rsp_en && mem_q.size() > 0 && mem_q[0].acc_cyc < cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    scoreCycle();
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic addVec(input logic r, input logic h, input logic rdy, input logic j,
                        input logic [31:0] ja, input logic rsp_en, input logic ev,
                        input logic [31:0] epc, input logic ereq, input logic [31:0] eaddr);
    vecs.push_back('{r, h, rdy, j, ja, rsp_en, ev, epc, ereq, eaddr});
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic seen;
    int   pops_before;

    // Streaming, hold, redirect with two in flight, redirect on a response,
    // then reset with a full buffer.
    addVec(0,0,1,0,0,1, 0,32'h000,1,32'h000);
    addVec(0,0,1,0,0,1, 0,32'h000,1,32'h004);
    addVec(0,0,1,0,0,1, 1,32'h000,1,32'h008);
    addVec(0,0,1,0,0,1, 1,32'h004,1,32'h00C);
    for (int k = 0; k < 5; k++) addVec(0,1,1,0,0,1, 1,32'h008,0,32'h010);
    addVec(0,0,1,0,0,1, 1,32'h008,1,32'h010);
    addVec(0,0,1,0,0,1, 1,32'h00C,1,32'h014);
    addVec(0,0,1,0,0,1, 1,32'h010,1,32'h018);
    addVec(0,0,1,0,0,0, 1,32'h014,1,32'h01C);
    addVec(0,0,1,1,32'h101,0, 0,32'h000,0,32'h020);
    addVec(0,0,1,0,0,1, 0,32'h000,0,32'h100);
    addVec(0,0,1,0,0,1, 0,32'h000,0,32'h100);
    addVec(0,0,1,0,0,1, 0,32'h000,1,32'h100);
    addVec(0,0,1,0,0,1, 0,32'h000,1,32'h104);
    addVec(0,0,1,0,0,1, 1,32'h100,1,32'h108);
    addVec(0,0,1,0,0,1, 1,32'h104,1,32'h10C);
    addVec(0,0,1,1,32'h200,1, 0,32'h000,0,32'h110);
    addVec(0,0,1,0,0,1, 0,32'h000,1,32'h200);
    addVec(0,0,1,0,0,1, 0,32'h000,1,32'h204);
    addVec(0,0,1,0,0,1, 1,32'h200,1,32'h208);
    addVec(0,0,1,0,0,1, 1,32'h204,1,32'h20C);
    addVec(0,1,1,0,0,1, 1,32'h208,0,32'h210);
    addVec(0,1,1,0,0,1, 1,32'h208,0,32'h210);
    addVec(1,1,1,0,0,1, 1,32'h208,0,32'h210);
    addVec(0,0,1,0,0,1, 0,32'h000,1,32'h000);
    addVec(0,0,1,0,0,1, 0,32'h000,1,32'h004);
    addVec(0,0,1,0,0,1, 1,32'h000,1,32'h008);

    // Reset and check the idle state while reset is still held.
    applyStimulus(1,0,1,0,0,0);
    tick();
    applyStimulus(1,0,1,0,0,0);
    checkOutput("reset_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("reset_pc", pc_o, 32'd0);
    checkOutput("reset_instr", instruction_o, DEFAULT_NOP_INSTR);
    checkOutput("reset_req", {31'd0, imem_req_valid}, 32'd0);
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].hold, vecs[i].ready, vecs[i].jump,
                    vecs[i].jaddr, vecs[i].rsp_en);
      checkOutput($sformatf("v%0d_valid", i), {31'd0, valid_o}, {31'd0, vecs[i].exp_valid});
      checkOutput($sformatf("v%0d_pc", i), pc_o, vecs[i].exp_pc);
      checkOutput($sformatf("v%0d_req", i), {31'd0, imem_req_valid}, {31'd0, vecs[i].exp_req});
      checkOutput($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      tick();
    end

    // Memory not ready for three cycles: the pending address must not move.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0,0,0,0,0,1);
      checkOutput($sformatf("stall%0d_req", k), {31'd0, imem_req_valid}, 32'd1);
      checkOutput($sformatf("stall%0d_addr", k), imem_addr, 32'h00C);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0,0,1,0,0,1);
      tick();
    end

    // Back-to-back redirects: the second target wins.
    applyStimulus(0,0,1,1,32'h300,0);
    tick();
    applyStimulus(0,0,1,1,32'h405,1);
    tick();
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      applyStimulus(0,0,1,0,0,1);
      if (valid_o) begin
        seen = 1'b1;
        checkOutput("b2b_first_pc", pc_o, 32'h404);
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL b2b_timeout: valid_o got 0 expected 1 within 12 cycles");
    end

    // Randomized traffic against the program-order model.
    pops_before = pops;
    for (int k = 0; k < 1500; k++) begin
      applyStimulus($urandom_range(0,199) == 0, $urandom_range(0,3) == 0,
                    $urandom_range(0,3) != 0, $urandom_range(0,31) == 0,
                    $urandom, $urandom_range(0,3) != 0);
      tick();
    end
    checks++;
    if (pops - pops_before < 150) begin
      errors++;
      $display("[TB] FAIL random_progress: got %0d pops expected at least 150", pops - pops_before);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction fetch stage sitting directly upstream of the IF/ID pipeline register.
- Owns the PC register and issues sequential fetch requests to instruction memory over a valid/ready request channel and an in-order response channel.
- Buffers up to 2 fetched {pc, instruction} pairs.
- Presents the buffer head to IF/ID, honouring the downstream hold and redirects from EX (branch/jump/flush).

Parameters:
- DATA_WIDTH, 32, instruction width (matches `DATA_WIDTH).
- BUS_WIDTH, 32, address/PC width (matches `BUS_WIDTH).
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on instruction_o when no valid entry.

Ports:
- clk  input  1  clock, all state on posedge.
- rst  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_addr  output  BUS_WIDTH  fetch address (word aligned).
- imem_rsp_valid  input  1  response data valid; in order, at least 1 cycle after acceptance.
- imem_rsp_data  input  DATA_WIDTH  fetched instruction.
- jump_en  input  1  redirect from EX (taken branch, jump, or flush).
- jump_addr  input  BUS_WIDTH  redirect target.
- hold  input  1  IF/ID stalled; do not pop.
- instruction_o  output  DATA_WIDTH  buffer head instruction, else NOP_INSTR.
- pc_o  output  BUS_WIDTH  buffer head PC, else 0.
- valid_o  output  1  head entry valid.

Behaviour:
- Reset (rst=1 at posedge):
  - pc_q=RESET_PC; outstanding=0; drop_cnt=0; buffer empty.
  - Outputs next cycle: valid_o=0, instruction_o=NOP_INSTR, pc_o=0, imem_req_valid=0.
  - Reset mid-operation discards all in-flight state. Instruction memory is reset on the same rst, so no stale responses arrive afterwards.
- Request issue:
  - imem_req_valid=1 when outstanding + count + drop_cnt < 2, jump_en=0 and rst=0.
  - imem_addr=pc_q, a combinational output.
  - On req_valid&req_ready: push pc_q into an in-flight PC queue (depth 2); outstanding+1; pc_q+=4. BUS_WIDTH arithmetic wraps at 2^BUS_WIDTH.
- Response:
  - On imem_rsp_valid with drop_cnt>0: discard it; drop_cnt-1; outstanding-1.
  - Otherwise pop the in-flight PC queue and push {pc, rsp_data} into the fetch buffer; outstanding-1.
  - The credit rule guarantees the buffer never overflows. A response with outstanding=0 is a protocol error: assertion, data ignored.
- Output / pop:
  - valid_o, pc_o and instruction_o are combinational from the buffer head.
  - Pop when valid_o & ~hold & ~jump_en.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Throughput is 1 instruction/cycle with a 1-cycle-latency memory.
- Redirect (jump_en=1, any hold value):
  - Fetch buffer cleared.
  - pc_q = {jump_addr[BUS_WIDTH-1:2], 2'b00}.
  - drop_cnt = outstanding minus 1 if a response arrives this same cycle (that response is also dropped).
  - In-flight PC queue cleared.
  - No request is issued in the redirect cycle; the first request to the target is issued the next cycle.
  - valid_o is forced to 0 in the redirect cycle.
  - Back-to-back redirects: the last one wins; drop_cnt accumulates correctly.
- Boundaries:
  - hold with buffer full: no requests issued, no pops.
  - hold releasing with a response arriving: pop and push together.
  - jump_addr misaligned: low bits cleared, no exception raised here.
- Latency: with a 1-cycle memory, the first valid_o comes 2 cycles after reset deassertion.

Decomposition:
- Shared include gains NOP_INSTR, RESET_PC and the PC increment constant (4).
- One sub-module, fetch_fifo: 2-entry synchronous FIFO with parameterised width and flush.
- Instantiated twice: in-flight PC queue (BUS_WIDTH) and fetch buffer (BUS_WIDTH+DATA_WIDTH).

Test Plan:
1. Reset, 1-cycle memory, ready=1, hold=0 → valid_o first high on the 2nd cycle after reset release; pc_o = 0,4,8,12 on consecutive cycles with the matching instructions.
2. hold=1 for 5 cycles mid-stream → pc_o holds (e.g. 8) throughout; at most 2 requests outstanding+buffered; after release pc_o 8,12,16 with no gap or duplicate.
3. jump_en with jump_addr=0x100 while 2 requests are outstanding → both old responses dropped; next valid pc_o=0x100 then 0x104; no 0x0C/0x10 ever shown.
4. jump_en coinciding with imem_rsp_valid → that response dropped; drop_cnt matches; next valid pc_o equals the target.
5. imem_req_ready low for 3 cycles → imem_addr stable at the pending PC; no pc skipped or duplicated.
6. rst asserted mid-stream with a full buffer → next cycle valid_o=0, instruction_o=0x00000013; first fetch address is 0x0.
